// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, sequence counter width and saturating event-counter helper.
package pipe_ctrl_pkg;

   localparam int CNT_W = 3;
   localparam int EVT_W = 16;
   localparam logic [EVT_W-1:0] EVT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v, input logic en);
      return (en && (v != EVT_MAX)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
   parameter int REG_W = 6
) ();

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rt;
   logic             idex_memread;
   logic [REG_W-1:0] idex_rd;
   logic             branch_taken;
   logic             mem_busy;
   logic             pc_we;
   logic             ifid_we;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             pipe_hold;
   logic [15:0]      stall_cnt;
   logic [15:0]      flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, idex_memread, idex_rd, branch_taken, mem_busy,
      input  pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rd, branch_taken, mem_busy,
      output pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: the instruction in ID reads the register a load in EX writes.
module load_use_detect #(
   parameter int REG_W = 6
) (
   input  logic             i_memread,
   input  logic [REG_W-1:0] i_ex_rd,
   input  logic [REG_W-1:0] i_rs,
   input  logic [REG_W-1:0] i_rt,
   input  logic             i_uses_rt,
   output logic             o_load_use
);

   logic w_rd_nz;
   logic w_hit_rs;
   logic w_hit_rt;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign w_rd_nz    = (i_ex_rd != '0);
   assign w_hit_rs   = (i_ex_rd == i_rs);
   assign w_hit_rt   = i_uses_rt && (i_ex_rd == i_rt);
   assign o_load_use = i_memread && w_rd_nz && (w_hit_rs || w_hit_rt);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory freeze, taken-branch flush and load-use stall sequencing.
// Also keeps saturating counts of stalled cycles and branch flush events.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W        = 6,
   parameter int FLUSH_CYCLES = 1,
   parameter int LOAD_STALL   = 1
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);

   // state    | meaning
   // ST_RUN   | normal issue; branch, load-use and memory-busy events evaluated
   // ST_STALL | load-use bubbles still owed; PC and IF/ID held
   // ST_FLUSH | post-branch squash cycles still owed; IF/ID and ID/EX get NOPs

   state_t r_state;
   state_t w_state_nxt;
   cnt_t   r_cnt;
   cnt_t   w_cnt_nxt;
   logic [EVT_W-1:0] r_stall_cnt;
   logic [EVT_W-1:0] r_flush_cnt;

   logic w_load_use;
   logic w_flush_evt;
   logic w_pc_we;
   logic w_ifid_we;
   logic w_ifid_flush;
   logic w_idex_bubble;
   logic w_pipe_hold;

   load_use_detect #(.REG_W(REG_W)) u_lud (
      .i_memread  (bus.idex_memread),
      .i_ex_rd    (bus.idex_rd),
      .i_rs       (bus.id_rs),
      .i_rt       (bus.id_rt),
      .i_uses_rt  (bus.id_uses_rt),
      .o_load_use (w_load_use)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_stall_cnt <= sat_inc(r_stall_cnt, !w_pc_we);
         r_flush_cnt <= sat_inc(r_flush_cnt, w_flush_evt);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_flush_evt   = 1'b0;
      w_pc_we       = 1'b1;
      w_ifid_we     = 1'b1;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_pipe_hold   = 1'b0;

      if (rst) begin
         w_pc_we       = 1'b0;
         w_ifid_we     = 1'b0;
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
         w_state_nxt   = ST_RUN;
         w_cnt_nxt     = '0;
      end else if (bus.mem_busy) begin
         // Whole pipe freezes; any in-progress stall/flush sequence resumes afterwards.
         w_pc_we     = 1'b0;
         w_ifid_we   = 1'b0;
         w_pipe_hold = 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (bus.branch_taken) begin
                  w_ifid_flush  = 1'b1;
                  w_idex_bubble = 1'b1;
                  w_flush_evt   = 1'b1;
                  w_cnt_nxt     = cnt_t'(FLUSH_CYCLES - 1);
                  w_state_nxt   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
               end else if (w_load_use) begin
                  w_pc_we       = 1'b0;
                  w_ifid_we     = 1'b0;
                  w_idex_bubble = 1'b1;
                  w_cnt_nxt     = cnt_t'(LOAD_STALL - 1);
                  w_state_nxt   = (LOAD_STALL > 1) ? ST_STALL : ST_RUN;
               end
            end
            ST_STALL: begin
               w_pc_we       = 1'b0;
               w_ifid_we     = 1'b0;
               w_idex_bubble = 1'b1;
               w_cnt_nxt     = r_cnt - cnt_t'(1);
               if (r_cnt == cnt_t'(1)) w_state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
               w_ifid_flush  = 1'b1;
               w_idex_bubble = 1'b1;
               w_cnt_nxt     = r_cnt - cnt_t'(1);
               if (r_cnt == cnt_t'(1)) w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.pc_we       = w_pc_we;
   assign bus.ifid_we     = w_ifid_we;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.idex_bubble = w_idex_bubble;
   assign bus.pipe_hold   = w_pipe_hold;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus a random phase,
// every cycle compared against a queue-based model of owed stall/flush cycles.
module tb_pipe_ctrl;

   localparam int RW = 6;
   localparam int FC = 2;
   localparam int LS = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;

   pipe_ctrl_if #(.REG_W(RW)) bus ();

   pipe_ctrl #(.REG_W(RW), .FLUSH_CYCLES(FC), .LOAD_STALL(LS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a queue of cycles still owed ("S" stall, "F" flush), consumed one per non-busy cycle.
   byte m_owed[$];
   int  m_stall;
   int  m_flush;

   always @(negedge clk) begin
      logic [4:0] exp_o;
      logic [4:0] act_o;
      logic       lu;
      lu = bus.idex_memread && (bus.idex_rd != 0) &&
           ((bus.idex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.idex_rd == bus.id_rt)));
      act_o = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble, bus.pipe_hold};

      check("stall_cnt", int'(bus.stall_cnt), m_stall);
      check("flush_cnt", int'(bus.flush_cnt), m_flush);

      if (rst) begin
         exp_o = 5'b00110;
         m_owed.delete();
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (bus.mem_busy) begin
            exp_o = 5'b00001;
         end else if (m_owed.size() > 0) begin
            exp_o = (m_owed[0] == "S") ? 5'b00010 : 5'b11110;
            void'(m_owed.pop_front());
         end else if (bus.branch_taken) begin
            exp_o = 5'b11110;
            m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            for (int k = 1; k < FC; k++) m_owed.push_back("F");
         end else if (lu) begin
            exp_o = 5'b00010;
            for (int k = 1; k < LS; k++) m_owed.push_back("S");
         end else begin
            exp_o = 5'b11000;
         end
         if (!exp_o[4]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      end
      check("ctrl_outs", int'(act_o), int'(exp_o));
   end

   task automatic drive(input logic r, input logic b, input logic br, input logic mr,
                        input int rd, input int rs, input int rt, input logic ut);
      @(posedge clk);
      #1;
      rst              = r;
      bus.mem_busy     = b;
      bus.branch_taken = br;
      bus.idex_memread = mr;
      bus.idex_rd      = RW'(rd);
      bus.id_rs        = RW'(rs);
      bus.id_rt        = RW'(rt);
      bus.id_uses_rt   = ut;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      m_stall  = 0;
      m_flush  = 0;
      rst              = 1'b1;
      bus.mem_busy     = 1'b0;
      bus.branch_taken = 1'b0;
      bus.idex_memread = 1'b0;
      bus.idex_rd      = '0;
      bus.id_rs        = '0;
      bus.id_rt        = '0;
      bus.id_uses_rt   = 1'b0;

      // Reset held 3 cycles with garbage on the other inputs
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 5, 5, 5, 1'b1);
         check("rst_flush", int'(bus.ifid_flush), 1);
         check("rst_bubble", int'(bus.idex_bubble), 1);
         check("rst_pc_we", int'(bus.pc_we), 0);
      end
      check("rst_stall_cnt", int'(bus.stall_cnt), 0);
      check("rst_flush_cnt", int'(bus.flush_cnt), 0);
      idle();
      check("first_free_pc_we", int'(bus.pc_we), 1);

      // Load-use on rs with LOAD_STALL=2
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5, 5, 0, 1'b0);
      check("lu_pc_we_c0", int'(bus.pc_we), 0);
      idle();
      check("lu_pc_we_c1", int'(bus.pc_we), 0);
      idle();
      check("lu_pc_we_c2", int'(bus.pc_we), 1);
      check("lu_stall_cnt", int'(bus.stall_cnt), 2);

      // Branch with FLUSH_CYCLES=2, second branch during flush ignored
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      check("br_flush_c0", int'(bus.ifid_flush), 1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      check("br_flush_c1", int'(bus.ifid_flush), 1);
      idle();
      check("br_flush_c2", int'(bus.ifid_flush), 0);
      check("br_flush_cnt", int'(bus.flush_cnt), 1);

      // Branch + load-use + mem_busy together: hold, then flush, never stall
      drive(1'b0, 1'b1, 1'b1, 1'b1, 5, 5, 0, 1'b0);
      check("sim_hold", int'(bus.pipe_hold), 1);
      check("sim_hold_pc_we", int'(bus.pc_we), 0);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 5, 5, 0, 1'b0);
      check("sim_flush", int'(bus.ifid_flush), 1);
      check("sim_flush_pc_we", int'(bus.pc_we), 1);
      idle();
      check("sim_flush2", int'(bus.ifid_flush), 1);
      idle();
      check("sim_stall_cnt", int'(bus.stall_cnt), 3);
      check("sim_flush_cnt", int'(bus.flush_cnt), 2);

      // rd=0 guard
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1);
      check("rd0_pc_we", int'(bus.pc_we), 1);
      check("rd0_bubble", int'(bus.idex_bubble), 0);

      // Load-use via rt only when rt is used
      drive(1'b0, 1'b0, 1'b0, 1'b1, 7, 3, 7, 1'b0);
      check("rt_unused_pc_we", int'(bus.pc_we), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 7, 3, 7, 1'b1);
      check("rt_used_pc_we", int'(bus.pc_we), 0);
      idle();
      idle();

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(63) == 0), 1'($urandom_range(7) == 0),
               1'($urandom_range(5) == 0), 1'($urandom_range(1)),
               int'($urandom_range(3)), int'($urandom_range(3)),
               int'($urandom_range(3)), 1'($urandom_range(1)));
      end

      // Saturation under a long memory freeze
      for (int i = 0; i < 70000; i++) begin
         drive(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 0, 0, 0, 1'b0);
      end
      idle();
      check("sat_stall_cnt", int'(bus.stall_cnt), 65535);
      idle();
      check("sat_stall_hold", int'(bus.stall_cnt), 65535);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_W, default 6: register-specifier width.
REQ-002 Parameter FLUSH_CYCLES, default 1, legal 1..7: cycles squashed after a taken branch.
REQ-003 Parameter LOAD_STALL, default 1, legal 1..7: bubble cycles inserted per load-use hazard.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 id_rs, id_rt  in  REG_W each  source registers of the instruction in ID.
REQ-007 id_uses_rt  in  1  the ID instruction reads rt.
REQ-008 idex_memread  in  1  the EX instruction is a load.
REQ-009 idex_rd  in  REG_W  destination register of the EX instruction.
REQ-010 branch_taken  in  1  a branch resolved taken in EX this cycle.
REQ-011 mem_busy  in  1  data memory is not ready; the whole pipe must freeze.
REQ-012 pc_we  out  1  PC write enable.
REQ-013 ifid_we  out  1  IF/ID buffer write enable.
REQ-014 ifid_flush  out  1  load NOP into IF/ID.
REQ-015 idex_bubble  out  1  load NOP into ID/EX.
REQ-016 pipe_hold  out  1  freeze EX/MEM and MEM/WB.
REQ-017 stall_cnt  out  16  saturating count of cycles with pc_we=0 outside reset.
REQ-018 flush_cnt  out  16  saturating count of taken-branch flush events.

Function
REQ-019 load_use SHALL be asserted when idex_memread=1, idex_rd!=0, and either idex_rd==id_rs or (id_uses_rt=1 and idex_rd==id_rt).
REQ-020 Outputs SHALL be combinational functions of rst, the current state, cnt and the inputs; state and cnt SHALL be registered.
REQ-021 The FSM SHALL have exactly three states: RUN, STALL and FLUSH; cnt SHALL be 3 bits wide.
REQ-022 mem_busy=1 in any state SHALL force pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0 and pipe_hold=1, and SHALL freeze state and cnt.
REQ-023 In RUN with branch_taken=1: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; cnt<=FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN; flush_cnt increments.
REQ-024 In RUN with branch_taken=0 and load_use=1: pc_we=0, ifid_we=0, idex_bubble=1; cnt<=LOAD_STALL-1; next state STALL if LOAD_STALL>1, else RUN.
REQ-025 In RUN with no event: pc_we=1, ifid_we=1, all other control outputs 0.
REQ-026 Priority within a cycle SHALL be mem_busy > branch_taken > load_use.
REQ-027 In STALL: pc_we=0, ifid_we=0, idex_bubble=1; branch_taken and load_use ignored; if cnt==1 next state RUN, else cnt decrements.
REQ-028 In FLUSH: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; branch_taken and load_use ignored; if cnt==1 next state RUN, else cnt decrements.
REQ-029 stall_cnt and flush_cnt SHALL stop at 16'hFFFF and not wrap.
REQ-030 Every asserted pipe_hold cycle SHALL also count as a stall cycle.

Reset
REQ-031 While rst=1: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_hold=0; all other inputs ignored.
REQ-032 On a clock edge with rst=1: state<=RUN, cnt<=0, stall_cnt<=0, flush_cnt<=0; a reset mid-STALL or mid-FLUSH SHALL abandon the sequence.
REQ-033 The first cycle after rst deasserts SHALL evaluate as RUN.

Structure
REQ-034 State encoding (RUN/STALL/FLUSH) and the counter width constant SHALL live in a shared package, pipe_ctrl_pkg.
REQ-035 The load_use comparison SHALL be a separate combinational sub-module, load_use_detect.

Verification
REQ-036 Reset: hold rst 3 cycles, then release -> ifid_flush=1 and idex_bubble=1 during reset, counters 0, and pc_we=1 on the first free cycle.
REQ-037 Load-use: idex_memread=1, idex_rd=5, id_rs=5, LOAD_STALL=2 -> pc_we=0 for 2 cycles, then RUN; stall_cnt=2.
REQ-038 Branch: branch_taken=1 with FLUSH_CYCLES=2 -> ifid_flush=1 for 2 cycles, a second branch_taken in FLUSH is ignored, and flush_cnt=1.
REQ-039 Simultaneous: branch_taken=1, load_use=1 and mem_busy=1 for 1 cycle, then mem_busy=0 -> hold first, flush next, and no stall.
REQ-040 rd=0 guard: idex_memread=1, idex_rd=0, id_rs=0 -> no stall.
REQ-041 Saturation: hold mem_busy for 70000 cycles -> stall_cnt=16'hFFFF.
